seg_scan_bcd: RTL and testbench

- Display stage directly downstream of the 8-bit lab counter: consumes the counter's 8-bit count value plus a sample strobe.
- Converts the binary value to three BCD digits with an iterative shift-add-3 (double-dabble) FSM.
- Drives a time-multiplexed 3-digit common-anode 7-segment display on the board.

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seg_scan_bcd_if.sv | 16 +
 rtl/seg_scan_bcd_bin2bcd_seq.sv | 105 ++++++++++
 rtl/seg_scan_bcd.sv | 87 ++++++++
 tb/tb_seg_scan_bcd.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the BCD display stage: segment patterns, converter
// FSM encoding, digit slot indices and small nibble helpers.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // Active-high patterns, bit order {dp,g,f,e,d,c,b,a}; dp is never lit.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [1:0] DIG_ONES     = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seg_scan_bcd_if.sv
// Sample/result bundle between the upstream counter and the display stage.
// bin_valid is a one-cycle strobe with no ready: the stage never stalls the
// source; a strobe during busy is parked in a one-deep slot, newest wins.
interface seg_scan_bcd_if;
  import seg_pkg::*;

  logic [7:0]  bin;
  logic        bin_valid;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  bcd_state_e  state;

  modport master (output bin, bin_valid, input busy, done, bcd, state);
  modport slave  (input bin, bin_valid, output busy, done, bcd, state);
endinterface

// File: rtl/seg_scan_bcd_bin2bcd_seq.sv
// Sequential double-dabble converter: 8 adjust-and-shift cycles per sample,
// with a one-deep pending slot so a new sample can start straight from DONE.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clock,
  input  logic        sclr,
  input  logic [7:0]  bin,
  input  logic        bin_valid,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output bcd_state_e  state
);

  bcd_state_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] scratch_q, scratch_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] bcd_q, bcd_d;

  always_comb begin
    adj        = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    case (state_q)
      IDLE: begin
        if (bin_valid) begin
          state_d   = SHIFT;
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 3'd1;
        if (bin_valid) begin
          pend_d     = bin;
          pend_vld_d = 1'b1;
        end
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        bcd_d  = scratch_q;
        done_d = 1'b1;
        // A strobe landing on this very cycle is newer than the parked one.
        if (bin_valid || pend_vld_q) begin
          state_d    = SHIFT;
          shift_d    = bin_valid ? bin : pend_q;
          scratch_d  = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          pend_vld_d = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign state = state_q;

endmodule

// File: rtl/seg_scan_bcd.sv
// Binary-to-BCD display stage driving a 3-digit multiplexed 7-segment panel.
// Define SEG_SCAN_BCD_BLANK_EN to blank leading zeros on hundreds and tens.
module seg_scan_bcd
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic           clock,
  input  logic           sclr,
  seg_scan_bcd_if.slave  bus,
  output logic [7:0]     seg,
  output logic [2:0]     dig_sel
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [2:0] DIG_OFF = {3{SEG_ACTIVE_LOW}};

  logic [11:0]   bcd_w;
  logic [PW-1:0] presc_q, presc_d;
  logic          wrap_q, wrap_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    dig_q, dig_d;
  logic [3:0]    digit;
  logic [2:0]    onehot;
  logic          blank;

  bin2bcd_seq u_conv (
    .clock     (clock),
    .sclr      (sclr),
    .bin       (bus.bin),
    .bin_valid (bus.bin_valid),
    .busy      (bus.busy),
    .done      (bus.done),
    .bcd       (bcd_w),
    .state     (bus.state)
  );

  assign bus.bcd = bcd_w;

  always_comb begin
    presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    wrap_d  = (presc_q == PRESC_MAX);
    idx_d   = idx_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    case (idx_q)
      DIG_TENS:     begin digit = bcd_w[7:4];  onehot = 3'b010; end
      DIG_HUNDREDS: begin digit = bcd_w[11:8]; onehot = 3'b100; end
      default:      begin digit = bcd_w[3:0];  onehot = 3'b001; end
    endcase
    blank = 1'b0;
`ifdef SEG_SCAN_BCD_BLANK_EN
    if (idx_q == DIG_HUNDREDS && bcd_w[11:8] == 4'd0) blank = 1'b1;
    if (idx_q == DIG_TENS && bcd_w[11:8] == 4'd0 && bcd_w[7:4] == 4'd0) blank = 1'b1;
`endif
    // Outputs follow the prescaler wrap by one cycle, then the slot advances.
    if (wrap_q) begin
      seg_d = (blank ? SEG_BLANK : seg_decode(digit)) ^ SEG_OFF;
      dig_d = onehot ^ DIG_OFF;
      idx_d = (idx_q == DIG_HUNDREDS) ? DIG_ONES : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      presc_q <= '0;
      wrap_q  <= 1'b0;
      idx_q   <= DIG_ONES;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Directed bench for seg_scan_bcd with SCAN_DIV=4 and active-low pins.
module tb_seg_scan_bcd;
  import seg_pkg::*;

  logic       clock = 1'b0;
  logic       sclr  = 1'b1;
  logic [7:0] seg;
  logic [2:0] dig_sel;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

`ifdef SEG_SCAN_BCD_BLANK_EN
  localparam logic [7:0] EXP0_TEN = 8'hFF, EXP0_HUN = 8'hFF;
  localparam logic [7:0] EXP7_TEN = 8'hFF, EXP7_HUN = 8'hFF;
`else
  localparam logic [7:0] EXP0_TEN = 8'hC0, EXP0_HUN = 8'hC0;
  localparam logic [7:0] EXP7_TEN = 8'hC0, EXP7_HUN = 8'hC0;
`endif

  seg_scan_bcd_if bus ();

  seg_scan_bcd #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock   (clock),
    .sclr    (sclr),
    .bus     (bus.slave),
    .seg     (seg),
    .dig_sel (dig_sel)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [7:0] v, input logic [11:0] exp);
    logic [11:0] e;
    exp_q.push_back(exp);
    bus.bin = v;
    bus.bin_valid = 1'b1;
    step();
    bus.bin_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("busy_shift", bus.busy, 1);
      chk("done_early", bus.done, 0);
    end
    step();
    e = exp_q.pop_front();
    chk("done_pulse", bus.done, 1);
    chk("bcd_value", bus.bcd, e);
    chk("busy_clear", bus.busy, 0);
    step();
    chk("done_drop", bus.done, 0);
    chk("state_idle", bus.state, IDLE);
  endtask

  task automatic scan_check(input logic [7:0] s_one, input logic [7:0] s_ten,
                            input logic [7:0] s_hun);
    int n;
    n = 0;
    repeat (12) step();
    while (dig_sel !== 3'b110 && n < 16) begin
      step();
      n++;
    end
    chk("scan_find_ones", (n < 16), 1);
    chk("seg_ones", seg, s_one);
    repeat (4) step();
    chk("dig_tens", dig_sel, 3'b101);
    chk("seg_tens", seg, s_ten);
    repeat (4) step();
    chk("dig_hundreds", dig_sel, 3'b011);
    chk("seg_hundreds", seg, s_hun);
    repeat (4) step();
    chk("dig_wrap_ones", dig_sel, 3'b110);
    chk("seg_wrap_ones", seg, s_one);
  endtask

  initial begin
    int n;
    logic [11:0] e;
    bus.bin = 8'd0;
    bus.bin_valid = 1'b0;

    // Reset held three cycles
    sclr = 1'b1;
    repeat (3) step();
    chk("rst_bcd", bus.bcd, 12'h000);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_state", bus.state, IDLE);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_dig", dig_sel, 3'b111);
    sclr = 1'b0;
    step();
    chk("pre_wrap_seg", seg, 8'hFF);
    chk("pre_wrap_dig", dig_sel, 3'b111);
    n = 0;
    while (dig_sel === 3'b111 && n < 16) begin
      step();
      n++;
    end
    chk("first_slot_dig", dig_sel, 3'b110);
    chk("first_slot_seg", seg, 8'hC0);
    repeat (4) step();
    chk("zero_tens_seg", seg, EXP0_TEN);
    repeat (4) step();
    chk("zero_hun_seg", seg, EXP0_HUN);

    // Single conversions
    convert(8'd100, 12'h100);
    convert(8'd255, 12'h255);
    convert(8'd0,   12'h000);
    convert(8'd99,  12'h099);

    // Back-to-back strobes: 58 is overwritten by 64 before DONE
    exp_q.push_back(12'h037);
    exp_q.push_back(12'h064);
    bus.bin = 8'd37; bus.bin_valid = 1'b1; step();
    bus.bin_valid = 1'b0; step(); step();
    bus.bin = 8'd58; bus.bin_valid = 1'b1; step();
    bus.bin_valid = 1'b0; step();
    bus.bin = 8'd64; bus.bin_valid = 1'b1; step();
    bus.bin_valid = 1'b0;
    repeat (3) begin
      step();
      chk("b2b_done_early", bus.done, 0);
    end
    step();
    e = exp_q.pop_front();
    chk("b2b_done_first", bus.done, 1);
    chk("b2b_bcd_first", bus.bcd, e);
    chk("b2b_no_idle_gap", bus.state, SHIFT);
    chk("b2b_busy_kept", bus.busy, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b2b_done_between", bus.done, 0);
    end
    step();
    e = exp_q.pop_front();
    chk("b2b_done_second", bus.done, 1);
    chk("b2b_bcd_second", bus.bcd, e);
    step();
    chk("b2b_done_drop", bus.done, 0);
    chk("b2b_state_idle", bus.state, IDLE);

    // Scan patterns
    convert(8'd123, 12'h123);
    scan_check(8'hB0, 8'hA4, 8'hF9);
    convert(8'd7, 12'h007);
    scan_check(8'hF8, EXP7_TEN, EXP7_HUN);

    // Reset during SHIFT abandons the conversion
    bus.bin = 8'd200; bus.bin_valid = 1'b1; step();
    bus.bin_valid = 1'b0;
    repeat (3) step();
    chk("mid_busy_before", bus.busy, 1);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_bcd", bus.bcd, 12'h000);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_state", bus.state, IDLE);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mid_rst_no_done", bus.done, 0);
    end
    chk("mid_rst_bcd_hold", bus.bcd, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
